// File: rtl/sram_arb_ctrl_if.sv
// Requester and macro-side signal bundle for sram_arb_ctrl.
// slave: controller view. master: host/test logic plus the macro.
interface sram_arb_ctrl_if #(
  parameter int DATA_WIDTH  = 4,
  parameter int ADDR_WIDTH  = 6,
  parameter int WMASK_WIDTH = 2
);
  logic                   r0_valid, r0_ready, r0_we, r0_rvalid;
  logic [WMASK_WIDTH-1:0] r0_wmask;
  logic [ADDR_WIDTH-1:0]  r0_addr;
  logic [DATA_WIDTH-1:0]  r0_din, r0_rdata;

  logic                   r1_valid, r1_ready, r1_we, r1_rvalid;
  logic [WMASK_WIDTH-1:0] r1_wmask;
  logic [ADDR_WIDTH-1:0]  r1_addr;
  logic [DATA_WIDTH-1:0]  r1_din, r1_rdata;

  logic                   mem_we;
  logic [WMASK_WIDTH-1:0] mem_wmask;
  logic [ADDR_WIDTH-1:0]  mem_addr;
  logic [DATA_WIDTH-1:0]  mem_din, mem_dout;
  logic                   busy;

  modport slave (
    input  r0_valid, r0_we, r0_wmask, r0_addr, r0_din,
    input  r1_valid, r1_we, r1_wmask, r1_addr, r1_din,
    input  mem_dout,
    output r0_ready, r0_rvalid, r0_rdata,
    output r1_ready, r1_rvalid, r1_rdata,
    output mem_we, mem_wmask, mem_addr, mem_din, busy
  );

  modport master (
    output r0_valid, r0_we, r0_wmask, r0_addr, r0_din,
    output r1_valid, r1_we, r1_wmask, r1_addr, r1_din,
    output mem_dout,
    input  r0_ready, r0_rvalid, r0_rdata,
    input  r1_ready, r1_rvalid, r1_rdata,
    input  mem_we, mem_wmask, mem_addr, mem_din, busy
  );
endinterface

// File: rtl/sram_arb_ctrl.sv
// Two-requester round-robin arbiter / sequencer for one sram22 macro port.
// Reads return one cycle after acceptance on the originating requester.
// Optional feature: define SRAM_ARB_CLEAR_EN to zero the whole macro after
// every reset before requests are accepted (busy high meanwhile).
module sram_arb_ctrl #(
  parameter int DATA_WIDTH  = 4,
  parameter int ADDR_WIDTH  = 6,
  parameter int WMASK_WIDTH = 2,
  parameter int RAM_DEPTH   = 1 << ADDR_WIDTH
) (
  input logic          clock,
  input logic          reset,
  sram_arb_ctrl_if.slave bus
);

  logic                   run;
  logic                   gnt0, gnt1;
  logic                   last_grant;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic                   pend_valid, pend_id;
  logic                   m_we;
  logic [WMASK_WIDTH-1:0] m_wmask;
  logic [ADDR_WIDTH-1:0]  m_addr;
  logic [DATA_WIDTH-1:0]  m_din;

`ifdef SRAM_ARB_CLEAR_EN
  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(RAM_DEPTH - 1);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] clr_cnt, clr_cnt_nxt;
  logic                  clearing;

  // State and clear counter; reset always restarts the sweep at word 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  // Sweep one word per cycle, then hand over to normal arbitration.
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    clearing    = 1'b0;
    run         = 1'b0;
    case (state)
      ST_CLEAR: begin
        clearing    = !reset;
        clr_cnt_nxt = clr_cnt + 1'b1;
        if (clr_cnt == LAST_WORD) state_nxt = ST_RUN;
      end
      ST_RUN:   run = !reset;
      default:  state_nxt = ST_CLEAR;
    endcase
  end

  assign bus.busy = clearing;
`else
  assign run      = !reset;
  assign bus.busy = 1'b0;
`endif

  // Round robin: a lone requester wins; on conflict the one not served last.
  assign gnt0 = run && bus.r0_valid && (!bus.r1_valid || last_grant);
  assign gnt1 = run && bus.r1_valid && (!bus.r0_valid || !last_grant);

  assign bus.r0_ready = gnt0;
  assign bus.r1_ready = gnt1;

  // Macro drive: granted request passes straight through; idle holds address.
  always_comb begin
    m_we    = 1'b0;
    m_wmask = '0;
    m_addr  = addr_q;
    m_din   = '0;
    if (gnt0) begin
      m_we    = bus.r0_we;
      m_wmask = bus.r0_wmask;
      m_addr  = bus.r0_addr;
      m_din   = bus.r0_din;
    end else if (gnt1) begin
      m_we    = bus.r1_we;
      m_wmask = bus.r1_wmask;
      m_addr  = bus.r1_addr;
      m_din   = bus.r1_din;
    end
`ifdef SRAM_ARB_CLEAR_EN
    if (clearing) begin
      m_we    = 1'b1;
      m_wmask = '1;
      m_addr  = clr_cnt;
      m_din   = '0;
    end
`endif
  end

  assign bus.mem_we    = m_we;
  assign bus.mem_wmask = m_wmask;
  assign bus.mem_addr  = m_addr;
  assign bus.mem_din   = m_din;

  // Grant history, held address and the one-deep read-return tag.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant <= 1'b1;
      addr_q     <= '0;
      pend_valid <= 1'b0;
      pend_id    <= 1'b0;
    end else begin
      if (gnt0 || gnt1) last_grant <= gnt1;
      addr_q     <= m_addr;
      pend_valid <= (gnt0 && !bus.r0_we) || (gnt1 && !bus.r1_we);
      pend_id    <= gnt1;
    end
  end

  // Macro dout is valid the cycle after the read edge; steer it to the owner.
  // Masked by reset so a read accepted just before reset never returns.
  assign bus.r0_rvalid = pend_valid && !pend_id && !reset;
  assign bus.r1_rvalid = pend_valid &&  pend_id && !reset;
  assign bus.r0_rdata  = bus.r0_rvalid ? bus.mem_dout : '0;
  assign bus.r1_rdata  = bus.r1_rvalid ? bus.mem_dout : '0;

endmodule

// File: tb/tb_sram_arb_ctrl.sv
// Bench for sram_arb_ctrl: directed scenarios plus constrained-random traffic,
// checked against a word-level memory image and a grant-alternation rule.
module tb_sram_arb_ctrl;
  localparam int DW = 4, AW = 6, MW = 2, DEPTH = 64;

  logic clock = 1'b0;
  logic reset = 1'b1;

  sram_arb_ctrl_if bus ();
  sram_arb_ctrl dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  // Requester drive, index 0/1 per requester
  logic [1:0]          v, we;
  logic [1:0][MW-1:0]  m;
  logic [1:0][AW-1:0]  a;
  logic [1:0][DW-1:0]  d;

  assign bus.r0_valid = v[0];  assign bus.r1_valid = v[1];
  assign bus.r0_we    = we[0]; assign bus.r1_we    = we[1];
  assign bus.r0_wmask = m[0];  assign bus.r1_wmask = m[1];
  assign bus.r0_addr  = a[0];  assign bus.r1_addr  = a[1];
  assign bus.r0_din   = d[0];  assign bus.r1_din   = d[1];

  // Behavioural sram22 port: masked write, registered read, dout held on write
  logic [DW-1:0] macro_mem [DEPTH];
  logic [DW-1:0] dout, wtmp;
  assign bus.mem_dout = dout;

  always @(posedge clock) begin
    if (bus.mem_we) begin
      wtmp = macro_mem[bus.mem_addr];
      for (int k = 0; k < MW; k++)
        if (bus.mem_wmask[k]) wtmp[k*(DW/MW) +: (DW/MW)] = bus.mem_din[k*(DW/MW) +: (DW/MW)];
      macro_mem[bus.mem_addr] <= wtmp;
    end else begin
      dout <= macro_mem[bus.mem_addr];
    end
  end

  // Reference state
  logic [DW-1:0] shadow [DEPTH];
  int            exp_last;
  logic          exp_pv;
  int            exp_pid;
  logic [DW-1:0] exp_pd;
  logic [AW-1:0] exp_addr;

  int checks, failures;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [MW-1:0] mk);
    merge = old;
    for (int j = 0; j < DW; j++) if (mk[j / (DW/MW)]) merge[j] = nw[j];
  endfunction

  // One clock of traffic: inputs already set just after a falling edge.
  task automatic cycle(output logic [1:0] g);
    logic [1:0]    eg;
    logic          npv;
    int            npid, w;
    logic [DW-1:0] npd;
    #2;
    if (v == 2'b11) eg = (exp_last == 1) ? 2'b01 : 2'b10;
    else            eg = v;
    chk("ready0", bus.r0_ready, eg[0]);
    chk("ready1", bus.r1_ready, eg[1]);
    chk("busy", bus.busy, 1'b0);
    chk("rvalid0", bus.r0_rvalid, exp_pv && exp_pid == 0);
    chk("rvalid1", bus.r1_rvalid, exp_pv && exp_pid == 1);
    if (exp_pv) chk("rdata", (exp_pid == 1) ? bus.r1_rdata : bus.r0_rdata, exp_pd);
    npv = 1'b0; npid = 0; npd = '0;
    if (eg != 2'b00) begin
      w = eg[1] ? 1 : 0;
      chk("mem_we", bus.mem_we, we[w]);
      chk("mem_addr", bus.mem_addr, a[w]);
      if (we[w]) begin
        chk("mem_din", bus.mem_din, d[w]);
        chk("mem_wmask", bus.mem_wmask, m[w]);
        shadow[a[w]] = merge(shadow[a[w]], d[w], m[w]);
      end else begin
        npv = 1'b1; npid = w; npd = shadow[a[w]];
      end
      exp_last = w;
      exp_addr = a[w];
    end else begin
      chk("idle_we", bus.mem_we, 1'b0);
      chk("idle_addr", bus.mem_addr, exp_addr);
    end
    g = eg;
    @(posedge clock);
    exp_pv = npv; exp_pid = npid; exp_pd = npd;
    @(negedge clock);
  endtask

  // Reset for one edge with both requesters asking; ready/rvalid must stay low.
  task automatic do_reset();
    reset = 1'b1;
    v = 2'b11; we = 2'b00;
    #2;
    chk("rst_ready0", bus.r0_ready, 1'b0);
    chk("rst_ready1", bus.r1_ready, 1'b0);
    chk("rst_rvalid0", bus.r0_rvalid, 1'b0);
    chk("rst_rvalid1", bus.r1_rvalid, 1'b0);
    chk("rst_rdata0", bus.r0_rdata, 4'h0);
    chk("rst_rdata1", bus.r1_rdata, 4'h0);
    chk("rst_busy", bus.busy, 1'b0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    exp_last = 1; exp_pv = 1'b0; exp_pid = 0; exp_addr = '0;
`ifdef SRAM_ARB_CLEAR_EN
    for (int i = 0; i < DEPTH; i++) begin
      #2;
      chk("clr_busy", bus.busy, 1'b1);
      chk("clr_ready0", bus.r0_ready, 1'b0);
      chk("clr_ready1", bus.r1_ready, 1'b0);
      chk("clr_we", bus.mem_we, 1'b1);
      chk("clr_wmask", bus.mem_wmask, 2'b11);
      chk("clr_addr", bus.mem_addr, i);
      chk("clr_din", bus.mem_din, 4'h0);
      shadow[i] = '0;
      @(posedge clock);
      @(negedge clock);
    end
    exp_addr = AW'(DEPTH - 1);
`endif
    v = 2'b00;
  endtask

  task automatic req(input int i, input logic w, input logic [MW-1:0] mk,
                     input logic [AW-1:0] ad, input logic [DW-1:0] dt);
    v[i] = 1'b1; we[i] = w; m[i] = mk; a[i] = ad; d[i] = dt;
  endtask

  logic [1:0] g, hold;

  initial begin
    checks = 0; failures = 0;
    for (int i = 0; i < DEPTH; i++) begin macro_mem[i] = '0; shadow[i] = '0; end
    dout = '0;
    v = '0; we = '0; m = '0; a = '0; d = '0;
    exp_last = 1; exp_pv = 1'b0; exp_pid = 0; exp_pd = '0; exp_addr = '0;
    @(negedge clock);
    do_reset();

    // Single write then read on r0
    v = '0; req(0, 1'b1, 2'b11, 6'h05, 4'hA); cycle(g);
    v = '0; req(0, 1'b0, 2'b00, 6'h05, 4'h0); cycle(g);
    v = '0;
    #1;
    chk("wr_rd_rvalid0", bus.r0_rvalid, 1'b1);
    chk("wr_rd_rdata0", bus.r0_rdata, 4'hA);
    chk("wr_rd_rvalid1", bus.r1_rvalid, 1'b0);
    cycle(g);

    // Masked write
    v = '0; req(0, 1'b1, 2'b11, 6'h10, 4'hF); cycle(g);
    v = '0; req(0, 1'b1, 2'b01, 6'h10, 4'h0); cycle(g);
    v = '0; req(0, 1'b0, 2'b00, 6'h10, 4'h0); cycle(g);
    v = '0;
    #1;
    chk("mask_rdata", bus.r0_rdata, 4'hC);
    cycle(g);

    // Pipelined reads on r1
    for (int i = 0; i < 4; i++) begin
      v = '0; req(1, 1'b1, 2'b11, AW'(i), DW'(i + 1)); cycle(g);
    end
    for (int i = 0; i < 4; i++) begin
      v = '0; req(1, 1'b0, 2'b00, AW'(i), 4'h0);
      if (i > 0) begin
        #1;
        chk("pipe_rvalid1", bus.r1_rvalid, 1'b1);
        chk("pipe_rdata1", bus.r1_rdata, i);
      end
      cycle(g);
    end
    v = '0;
    #1;
    chk("pipe_rvalid1_last", bus.r1_rvalid, 1'b1);
    chk("pipe_rdata1_last", bus.r1_rdata, 4'h4);
    cycle(g);

    // Contention fairness right after reset: 0,1,0,1,0,1
    do_reset();
    for (int k = 0; k < 6; k++) begin
      req(0, 1'b0, 2'b00, 6'h05, 4'h0);
      req(1, 1'b0, 2'b00, 6'h10, 4'h0);
      #1;
      chk("fair_grant", {bus.r1_ready, bus.r0_ready}, (k % 2 == 0) ? 2'b01 : 2'b10);
      cycle(g);
    end
    v = '0; cycle(g);

    // Reset right after a read is accepted: the return is dropped
    v = '0; req(0, 1'b0, 2'b00, 6'h05, 4'h0); cycle(g);
    do_reset();
    req(0, 1'b0, 2'b00, 6'h01, 4'h0);
    req(1, 1'b0, 2'b00, 6'h02, 4'h0);
    #1;
    chk("post_rst_ready0", bus.r0_ready, 1'b1);
    chk("post_rst_ready1", bus.r1_ready, 1'b0);
    cycle(g);
    v = '0; cycle(g);

    // Random traffic; a requester keeps its request until it is accepted
    hold = '0;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!hold[i]) begin
          v[i]  = ($urandom_range(0, 3) != 0);
          we[i] = 1'($urandom_range(0, 1));
          m[i]  = MW'($urandom_range(0, 3));
          a[i]  = AW'($urandom_range(0, 7));
          d[i]  = DW'($urandom_range(0, 15));
        end
      end
      cycle(g);
      hold = v & ~g;
    end
    v = '0; cycle(g);

`ifdef SRAM_ARB_CLEAR_EN
    // Clear after reset wipes preloaded data
    v = '0; req(0, 1'b1, 2'b11, 6'h3F, 4'h7); cycle(g);
    v = '0; cycle(g);
    do_reset();
    v = '0; req(0, 1'b0, 2'b00, 6'h3F, 4'h0); cycle(g);
    v = '0;
    #1;
    chk("clr_rvalid", bus.r0_rvalid, 1'b1);
    chk("clr_rdata", bus.r0_rdata, 4'h0);
    cycle(g);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
